reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Write-port controller for a bank of `NREG` 16-bit enable-gated register cells shared by two requesters. Port A is the program-counter path and port B is the shifter path. It arbitrates round-robin between them, registers the winning index and data, and drives one-hot per-register enables plus a shared write-data bus. It sits between the PC/shifter logic and the register bank; the bank itself is outside this block.

## Interface
- `NREG`, default 4: number of register cells driven; range 2..4.
- `IDXW`, default 2: register index width.
- `clk`  in  1: rising-edge clock shared with the register bank.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: blocks new grants while high.
- `a_req`  in  1: port A write request.
- `a_idx`  in  IDXW: port A target register.
- `a_data`  in  16: port A write data.
- `a_gnt`  out  1: port A request accepted this cycle.
- `b_req`, `b_idx`, `b_data`, `b_gnt`: same as port A, for port B.
- `wr_en`  out  NREG: one-hot enables to the register cells' `En` inputs.
- `wr_data`  out  16: shared data bus to the register cells' `in` inputs.
- `wr_src`  out  1: source of the current write (0 = A, 1 = B); valid while `|wr_en`.
- `err`  out  1: one-cycle pulse when an accepted index is ≥ NREG.
- `busy`  out  1: the write stage holds a valid write.

## Operation
- Handshake:
  - A requester holds `req`, `idx` and `data` stable until it samples its `gnt` high.
  - `gnt` is combinational, is high for the accepting cycle only, and is never high for both ports in the same cycle.
  - A requester keeping `req` high after `gnt` presents a new write.
- Arbitration uses a 1-bit pointer `prio` (0 = A favoured, 1 = B favoured):
  - `stall` = 1 or `rst` = 1: no grant.
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port selected by `prio` is granted.
  - After any grant, `prio` points to the non-granted port.
  - `prio` is unchanged in cycles with no grant.
- Write stage (single pipeline register `{vld, idx, data, src}`):
  - Loaded on every grant edge; `vld` is cleared on edges with no grant.
  - Back-to-back grants are allowed, so throughput is one write per cycle.
  - `wr_en[idx]` = `vld` & (idx < NREG). `wr_data` = registered data. `wr_src` = registered source.
  - `wr_data` holds its last value when `vld` = 0.
- Out-of-range index: the request is granted and consumed with no enable asserted, and `err` pulses during the write-stage cycle.
- `stall` does not block the write stage; an already-accepted write always issues.
- Simultaneous requests to the same index: both writes are issued in grant order, so the later write wins in the register.
- Reset values: `wr_en` = 0, `wr_data` = 16'h0000, `wr_src` = 0, `err` = 0, `busy` = 0, `prio` = 0, `vld` = 0.
- Reset mid-operation drops any pending write; the register is not updated.

## Timing
- Request accepted (`gnt` high) in cycle N.
- `wr_en` / `wr_data` valid in cycle N+1.
- Register cell updates at the end of cycle N+1 (edge N+2).
- `busy` = `vld`; it is high in cycle N+1.
- `err` is high in cycle N+1 only.
- `rst` sampled high at an edge makes all outputs show their reset values from that edge on; `gnt` is 0 during every cycle in which `rst` is high.
- `stall` asserted in cycle N blocks grants in cycle N; the write accepted in N−1 still issues in N.

## Structure
- Shared package `reg_pkg`:
  - `DATA_W` = 16.
  - Source encoding `SRC_A` = 1'b0, `SRC_B` = 1'b1.
  - Default `NREG` / `IDXW`.
- Sub-module `rr_arb2`:
  - Inputs: `clk`, `rst`, `req[1:0]`, `en`.
  - Outputs: `gnt[1:0]`.
  - Holds the `prio` flop.
  - Reused by the shifter control path.
- Top level contains the write-stage register and the index decoder.

## Test plan
- Reset: drive `rst` = 1 for 2 cycles with `a_req` = 1 → `a_gnt` = 0, `wr_en` = 0, `wr_data` = 0; after release, the first grant goes to A.
- Single port: A writes idx 2, data 16'hBEEF at cycle N → `a_gnt` in N; `wr_en` = 4'b0100, `wr_data` = 16'hBEEF, `wr_src` = 0 in N+1.
- Contention: A and B request continuously for 4 cycles → grant order A, B, A, B; `wr_en` issues each cycle after its grant.
- Stall: stall during a pending write → the pending write still issues; no `gnt` while stalled; grants resume the cycle after `stall` falls, with `prio` preserved.
- Out of range: `NREG` = 3, B requests idx 3 → `b_gnt` = 1; next cycle `wr_en` = 0 and `err` = 1 for one cycle.
- Reset mid-op: grant in cycle N, `rst` = 1 in N → `wr_en` = 0 in N+1; the register is unchanged.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared definitions for the register-bank write path.
package reg_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NREG_DEF = 4;
    localparam int unsigned IDXW_DEF = 2;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a single priority flop and a grant enable.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic prio;

    always_comb begin
        gnt = 2'b00;
        if (en && !rst) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = prio ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Point at the loser so it wins the next contended cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (gnt[0]) begin
            prio <= 1'b1;
        end else if (gnt[1]) begin
            prio <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates PC (A) and shifter (B) writes into a register bank through a
// one-deep write stage driving one-hot enables and a shared data bus.
module reg_write_arbiter
    import reg_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned IDXW = IDXW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              a_req,
    input  logic [IDXW-1:0]   a_idx,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_gnt,
    input  logic              b_req,
    input  logic [IDXW-1:0]   b_idx,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_gnt,
    output logic [NREG-1:0]   wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_src,
    output logic              err,
    output logic              busy
);

    localparam logic [IDXW:0] NREG_W = NREG[IDXW:0];

    logic [1:0]        gnt;
    logic              vld_q;
    logic [IDXW-1:0]   idx_q;
    logic [DATA_W-1:0] data_q;
    logic              src_q;
    logic              in_range;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({b_req, a_req}),
        .en  (~stall),
        .gnt (gnt)
    );

    assign a_gnt = gnt[0];
    assign b_gnt = gnt[1];

    // Data/index/source hold their last value when idle so the bus stays quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            idx_q  <= '0;
            data_q <= '0;
            src_q  <= SRC_A;
        end else begin
            vld_q <= |gnt;
            if (|gnt) begin
                idx_q  <= gnt[1] ? b_idx : a_idx;
                data_q <= gnt[1] ? b_data : a_data;
                src_q  <= gnt[1] ? SRC_B : SRC_A;
            end
        end
    end

    assign in_range = ({1'b0, idx_q} < NREG_W);

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NREG; i++) begin
            wr_en[i] = vld_q && (idx_q == IDXW'(i));
        end
    end

    assign wr_data = data_q;
    assign wr_src  = src_q;
    assign err     = vld_q & ~in_range;
    assign busy    = vld_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter; a 4-register and a 3-register instance share stimulus.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic        a_req, b_req;
    logic [1:0]  a_idx, b_idx;
    logic [15:0] a_data, b_data;

    logic        a_gnt4, b_gnt4, wr_src4, err4, busy4;
    logic [3:0]  wr_en4;
    logic [15:0] wr_data4;
    logic        a_gnt3, b_gnt3, wr_src3, err3, busy3;
    logic [2:0]  wr_en3;
    logic [15:0] wr_data3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_write_arbiter #(.NREG(4), .IDXW(2)) dut4 (
        .clk(clk), .rst(rst), .stall(stall),
        .a_req(a_req), .a_idx(a_idx), .a_data(a_data), .a_gnt(a_gnt4),
        .b_req(b_req), .b_idx(b_idx), .b_data(b_data), .b_gnt(b_gnt4),
        .wr_en(wr_en4), .wr_data(wr_data4), .wr_src(wr_src4), .err(err4), .busy(busy4)
    );

    reg_write_arbiter #(.NREG(3), .IDXW(2)) dut3 (
        .clk(clk), .rst(rst), .stall(stall),
        .a_req(a_req), .a_idx(a_idx), .a_data(a_data), .a_gnt(a_gnt3),
        .b_req(b_req), .b_idx(b_idx), .b_data(b_data), .b_gnt(b_gnt3),
        .wr_en(wr_en3), .wr_data(wr_data3), .wr_src(wr_src3), .err(err3), .busy(busy3)
    );

    // Advance past an edge; inputs are then driven and outputs sampled mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0;
        a_req = 1'b1; a_idx = 2'd1; a_data = 16'h1111;
        b_req = 1'b0; b_idx = 2'd0; b_data = 16'h0000;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({a_gnt4, b_gnt4, a_gnt3, b_gnt3} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_gnt: got %b expected 0000", {a_gnt4, b_gnt4, a_gnt3, b_gnt3});
            end
            checks++;
            if ({wr_en4, wr_data4, wr_src4, err4, busy4} !== 23'h0) begin
                failures++;
                $display("FAIL reset_outs: got en=%b data=%h src=%b err=%b busy=%b expected all zero",
                         wr_en4, wr_data4, wr_src4, err4, busy4);
            end
            checks++;
            if ({wr_en3, wr_data3, wr_src3, err3, busy3} !== 22'h0) begin
                failures++;
                $display("FAIL reset_outs3: got en=%b data=%h expected zero", wr_en3, wr_data3);
            end
        end
        rst = 1'b0;
        b_req = 1'b1; b_idx = 2'd3; b_data = 16'h2222;
        #1;
        checks++;
        if ({a_gnt4, b_gnt4} !== 2'b10) begin
            failures++;
            $display("FAIL reset_first_grant: got a=%b b=%b expected a=1 b=0", a_gnt4, b_gnt4);
        end
        step();
        a_req = 1'b0; b_req = 1'b0;
        #1;
        checks++;
        if ({wr_en4, wr_data4, wr_src4, busy4} !== {4'b0010, 16'h1111, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_first_write: got en=%b data=%h src=%b busy=%b expected 0010 1111 0 1",
                     wr_en4, wr_data4, wr_src4, busy4);
        end
        step();
        checks++;
        if ({wr_en4, wr_data4, busy4} !== {4'b0000, 16'h1111, 1'b0}) begin
            failures++;
            $display("FAIL idle_hold: got en=%b data=%h busy=%b expected 0000 1111 0",
                     wr_en4, wr_data4, busy4);
        end
    endtask

    // prio = 1 on entry.
    task automatic test_single();
        a_req = 1'b1; a_idx = 2'd2; a_data = 16'hBEEF;
        #1;
        checks++;
        if ({a_gnt4, b_gnt4} !== 2'b10) begin
            failures++;
            $display("FAIL single_gnt: got a=%b b=%b expected a=1 b=0", a_gnt4, b_gnt4);
        end
        step();
        a_req = 1'b0;
        #1;
        checks++;
        if ({wr_en4, wr_data4, wr_src4, err4} !== {4'b0100, 16'hBEEF, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL single_write: got en=%b data=%h src=%b err=%b expected 0100 beef 0 0",
                     wr_en4, wr_data4, wr_src4, err4);
        end
        checks++;
        if (wr_en3 !== 3'b100) begin
            failures++;
            $display("FAIL single_write3: got en=%b expected 100", wr_en3);
        end
        step();
    endtask

    // prio = 1 on entry; a lone B write swings it back to A before contention.
    task automatic test_contention();
        logic [3:0] exp_en;
        b_req = 1'b1; b_idx = 2'd1; b_data = 16'h0B0B;
        #1;
        checks++;
        if ({a_gnt4, b_gnt4} !== 2'b01) begin
            failures++;
            $display("FAIL b_only_gnt: got a=%b b=%b expected a=0 b=1", a_gnt4, b_gnt4);
        end
        step();
        b_req = 1'b0;
        #1;
        checks++;
        if ({wr_en4, wr_data4, wr_src4} !== {4'b0010, 16'h0B0B, 1'b1}) begin
            failures++;
            $display("FAIL b_only_write: got en=%b data=%h src=%b expected 0010 0b0b 1",
                     wr_en4, wr_data4, wr_src4);
        end
        a_idx = 2'd0; a_data = 16'hA0A0;
        b_idx = 2'd3; b_data = 16'hB0B0;
        for (int i = 0; i < 5; i++) begin
            a_req = (i < 4); b_req = (i < 4);
            #1;
            checks++;
            if (i < 4 && {a_gnt4, b_gnt4} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL contend_gnt[%0d]: got a=%b b=%b expected %s", i, a_gnt4, b_gnt4,
                         (i % 2 == 0) ? "A" : "B");
            end else if (i == 4 && {a_gnt4, b_gnt4} !== 2'b00) begin
                failures++;
                $display("FAIL contend_gnt[%0d]: got a=%b b=%b expected none", i, a_gnt4, b_gnt4);
            end
            if (i > 0) begin
                exp_en = ((i - 1) % 2 == 0) ? 4'b0001 : 4'b1000;
                checks++;
                if ({wr_en4, wr_data4, wr_src4} !==
                    {exp_en, ((i - 1) % 2 == 0) ? 16'hA0A0 : 16'hB0B0, ((i - 1) % 2 == 1)}) begin
                    failures++;
                    $display("FAIL contend_write[%0d]: got en=%b data=%h src=%b expected en=%b",
                             i, wr_en4, wr_data4, wr_src4, exp_en);
                end
            end
            step();
        end
    endtask

    // prio = 0 on entry.
    task automatic test_stall();
        a_req = 1'b1; a_idx = 2'd1; a_data = 16'h5555;
        #1;
        checks++;
        if ({a_gnt4, b_gnt4} !== 2'b10) begin
            failures++;
            $display("FAIL stall_pre_gnt: got a=%b b=%b expected a=1 b=0", a_gnt4, b_gnt4);
        end
        step();
        stall = 1'b1;
        a_idx = 2'd2; a_data = 16'h6666;
        b_req = 1'b1; b_idx = 2'd3; b_data = 16'h7777;
        #1;
        checks++;
        if ({a_gnt4, b_gnt4, a_gnt3, b_gnt3} !== 4'b0000) begin
            failures++;
            $display("FAIL stall_gnt: got %b expected 0000", {a_gnt4, b_gnt4, a_gnt3, b_gnt3});
        end
        checks++;
        if ({wr_en4, wr_data4, busy4} !== {4'b0010, 16'h5555, 1'b1}) begin
            failures++;
            $display("FAIL stall_issue: got en=%b data=%h busy=%b expected 0010 5555 1",
                     wr_en4, wr_data4, busy4);
        end
        step();
        checks++;
        if ({a_gnt4, b_gnt4, wr_en4, busy4} !== 7'b0) begin
            failures++;
            $display("FAIL stall_idle: got gnt=%b%b en=%b busy=%b expected all zero",
                     a_gnt4, b_gnt4, wr_en4, busy4);
        end
        step();
        stall = 1'b0;
        #1;
        checks++;
        if ({a_gnt4, b_gnt4} !== 2'b01) begin
            failures++;
            $display("FAIL stall_resume_prio: got a=%b b=%b expected a=0 b=1", a_gnt4, b_gnt4);
        end
        step();
        b_req = 1'b0;
        #1;
        checks++;
        if ({a_gnt4, wr_en4, wr_data4, wr_src4} !== {1'b1, 4'b1000, 16'h7777, 1'b1}) begin
            failures++;
            $display("FAIL stall_resume_b: got agnt=%b en=%b data=%h src=%b expected 1 1000 7777 1",
                     a_gnt4, wr_en4, wr_data4, wr_src4);
        end
        step();
        a_req = 1'b0;
        #1;
        checks++;
        if ({wr_en4, wr_data4, wr_src4} !== {4'b0100, 16'h6666, 1'b0}) begin
            failures++;
            $display("FAIL stall_resume_a: got en=%b data=%h src=%b expected 0100 6666 0",
                     wr_en4, wr_data4, wr_src4);
        end
        step();
    endtask

    // prio = 1 on entry.
    task automatic test_out_of_range();
        b_req = 1'b1; b_idx = 2'd3; b_data = 16'h3333;
        #1;
        checks++;
        if ({a_gnt3, b_gnt3} !== 2'b01) begin
            failures++;
            $display("FAIL oor_gnt: got a=%b b=%b expected a=0 b=1", a_gnt3, b_gnt3);
        end
        step();
        b_req = 1'b0;
        #1;
        checks++;
        if ({wr_en3, err3, busy3, wr_data3} !== {3'b000, 1'b1, 1'b1, 16'h3333}) begin
            failures++;
            $display("FAIL oor_write3: got en=%b err=%b busy=%b data=%h expected 000 1 1 3333",
                     wr_en3, err3, busy3, wr_data3);
        end
        checks++;
        if ({wr_en4, err4} !== {4'b1000, 1'b0}) begin
            failures++;
            $display("FAIL oor_write4: got en=%b err=%b expected 1000 0", wr_en4, err4);
        end
        step();
        checks++;
        if ({err3, wr_en3} !== 4'b0) begin
            failures++;
            $display("FAIL oor_err_pulse: got err=%b en=%b expected 0 000", err3, wr_en3);
        end
    endtask

    task automatic test_reset_midop();
        a_req = 1'b1; a_idx = 2'd0; a_data = 16'h9999;
        rst = 1'b1;
        #1;
        checks++;
        if ({a_gnt4, b_gnt4} !== 2'b00) begin
            failures++;
            $display("FAIL midrst_gnt: got a=%b b=%b expected 0 0", a_gnt4, b_gnt4);
        end
        step();
        rst = 1'b0; a_req = 1'b0;
        #1;
        checks++;
        if ({wr_en4, busy4, err4, wr_data4, wr_src4} !== 23'h0) begin
            failures++;
            $display("FAIL midrst_drop: got en=%b busy=%b err=%b data=%h src=%b expected all zero",
                     wr_en4, busy4, err4, wr_data4, wr_src4);
        end
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_out_of_range();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
